fc_chain_ctrl: RTL and testbench

Handshake-driven sequencer for a chain of fully-connected layers in the classifier back end. It replaces fixed cycle-count scheduling with explicit start/done handshakes to the activation and softmax units. It generates per-layer weight-memory addresses and per-layer resets for 1 to 4 layers, and adds abort, timeout and error reporting. It sits between the feature extractor's output bus and the layer, activation and softmax datapath instances.

---
 rtl/fc_chain_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fc_chain_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_chain_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fc_chain_ctrl: handshake sequencer for a 1..4 layer fully-connected chain.
// rev 1.0
// ---------------------------------------------------------------------------
module fc_chain_ctrl #(
   parameter int          NUM_LAYERS     = 2,
   parameter logic [63:0] IN_NODES_VEC   = {16'd0, 16'd0, 16'd84, 16'd120},
   parameter int          ADDR_WIDTH     = 8,
   parameter int          DRAIN_CYCLES   = 2,
   parameter int          TIMEOUT_CYCLES = 1023
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  act_done_i,
   input  logic                  smax_done_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [1:0]            layer_idx_o,
   output logic [NUM_LAYERS-1:0] layer_rst_o,
   output logic [ADDR_WIDTH-1:0] w_addr_o,
   output logic                  w_addr_valid_o,
   output logic                  act_start_o,
   output logic [1:0]            act_sel_o,
   output logic                  smax_en_o
);

   localparam int          DW         = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0]  LAST_LAYER = 2'(NUM_LAYERS - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_ACT, S_SMAX, S_DONE, S_ERROR
   } state_t;

   state_t                  state_q;
   logic [DW-1:0]           drain_q;
   logic [TW-1:0]           tmo_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    error_q;
   logic [1:0]              layer_idx_q;
   logic [NUM_LAYERS-1:0]   layer_rst_q;
   logic [ADDR_WIDTH-1:0]   w_addr_q;
   logic                    w_addr_vld_q;
   logic                    act_start_q;
   logic [1:0]              act_sel_q;
   logic                    smax_en_q;

   logic [ADDR_WIDTH-1:0]   last_addr [4];
   logic [1:0]              nxt_idx_d;
   logic                    at_last_d;
   logic                    wait_done_d;
   logic                    to_wait_d;
   logic                    tmo_hit_d;

   for (genvar g = 0; g < 4; g++) begin : g_last
      localparam logic [15:0] C_LAST16 = IN_NODES_VEC[16*g +: 16] - 16'd1;
      assign last_addr[g] = C_LAST16[ADDR_WIDTH-1:0];
   end

   assign nxt_idx_d   = layer_idx_q + 2'd1;
   assign at_last_d   = (w_addr_q == last_addr[layer_idx_q]);
   // act_done in the act_start cycle belongs to a previous request and is ignored
   assign wait_done_d = (state_q == S_ACT) ? (act_done_i && !act_start_q) : smax_done_i;
   assign to_wait_d   = ((state_q == S_LOAD) && at_last_d && (DRAIN_CYCLES == 0)) ||
                        ((state_q == S_DRAIN) && (drain_q == DRAIN_LAST));
   assign tmo_hit_d   = ((state_q == S_ACT) || (state_q == S_SMAX)) &&
                        !wait_done_d && (tmo_q == TMO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         drain_q      <= '0;
         tmo_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         layer_idx_q  <= 2'd0;
         layer_rst_q  <= '1;
         w_addr_q     <= '0;
         w_addr_vld_q <= 1'b0;
         act_start_q  <= 1'b0;
         act_sel_q    <= 2'd0;
         smax_en_q    <= 1'b0;
      end else if (abort_i && busy_q) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         layer_idx_q  <= 2'd0;
         layer_rst_q  <= '1;
         w_addr_q     <= '0;
         w_addr_vld_q <= 1'b0;
         act_start_q  <= 1'b0;
         act_sel_q    <= 2'd0;
         smax_en_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ERROR: begin
               if (start_i) begin
                  state_q     <= S_CLEAR;
                  busy_q      <= 1'b1;
                  error_q     <= 1'b0;
                  layer_idx_q <= 2'd0;
                  layer_rst_q <= '1;
               end
            end
            S_CLEAR: begin
               state_q        <= S_LOAD;
               w_addr_q       <= '0;
               w_addr_vld_q   <= 1'b1;
               layer_rst_q[0] <= 1'b0;
            end
            S_LOAD: begin
               if (at_last_d) begin
                  w_addr_vld_q <= 1'b0;
                  state_q      <= S_DRAIN;
                  drain_q      <= '0;
               end else begin
                  w_addr_q <= w_addr_q + 1'b1;
               end
            end
            S_DRAIN: drain_q <= drain_q + 1'b1;
            S_ACT: begin
               act_start_q <= 1'b0;
               if (wait_done_d) begin
                  state_q      <= S_LOAD;
                  layer_idx_q  <= nxt_idx_d;
                  w_addr_q     <= '0;
                  w_addr_vld_q <= 1'b1;
                  for (int i = 0; i < NUM_LAYERS; i++) begin
                     if (2'(i) == nxt_idx_d) layer_rst_q[i] <= 1'b0;
                  end
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_SMAX: begin
               if (wait_done_d) begin
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  smax_en_q <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // These override the per-state defaults above for the same edge
         if (to_wait_d) begin
            tmo_q <= '0;
            if (layer_idx_q == LAST_LAYER) begin
               state_q   <= S_SMAX;
               smax_en_q <= 1'b1;
            end else begin
               state_q     <= S_ACT;
               act_start_q <= 1'b1;
               act_sel_q   <= layer_idx_q;
            end
         end
         if (tmo_hit_d) begin
            state_q     <= S_ERROR;
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            smax_en_q   <= 1'b0;
            act_start_q <= 1'b0;
            layer_rst_q <= '1;
         end
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign layer_idx_o    = layer_idx_q;
   assign layer_rst_o    = layer_rst_q;
   assign w_addr_o       = w_addr_q;
   assign w_addr_valid_o = w_addr_vld_q;
   assign act_start_o    = act_start_q;
   assign act_sel_o      = act_sel_q;
   assign smax_en_o      = smax_en_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_chain_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fc_chain_ctrl: scoreboard bench for fc_chain_ctrl with a timeline model.
// rev 1.0
// ---------------------------------------------------------------------------
module tb_fc_chain_ctrl;

   localparam int NL   = 2;
   localparam int DR   = 2;
   localparam int TMO  = 1023;
   localparam int BIG  = 1 << 20;
   localparam int NODES [NL] = '{120, 84};

   logic clk = 1'b0;
   logic reset;
   logic start_i, abort_i, act_done_i, smax_done_i;
   logic busy_o, done_o, error_o, w_addr_valid_o, act_start_o, smax_en_o;
   logic [1:0] layer_idx_o, act_sel_o, layer_rst_o;
   logic [7:0] w_addr_o;

   logic s1_start, s1_abort, s1_act_done, s1_smax_done;
   logic s1_busy, s1_done, s1_error, s1_valid, s1_act_start, s1_smax_en;
   logic [1:0] s1_layer_idx, s1_act_sel;
   logic [0:0] s1_rst;
   logic [7:0] s1_addr;

   fc_chain_ctrl dut (
      .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
      .act_done_i(act_done_i), .smax_done_i(smax_done_i), .busy_o(busy_o),
      .done_o(done_o), .error_o(error_o), .layer_idx_o(layer_idx_o),
      .layer_rst_o(layer_rst_o), .w_addr_o(w_addr_o), .w_addr_valid_o(w_addr_valid_o),
      .act_start_o(act_start_o), .act_sel_o(act_sel_o), .smax_en_o(smax_en_o)
   );

   fc_chain_ctrl #(
      .NUM_LAYERS(1), .IN_NODES_VEC(64'd4), .ADDR_WIDTH(8),
      .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(1023)
   ) dut1 (
      .clk(clk), .reset(reset), .start_i(s1_start), .abort_i(s1_abort),
      .act_done_i(s1_act_done), .smax_done_i(s1_smax_done), .busy_o(s1_busy),
      .done_o(s1_done), .error_o(s1_error), .layer_idx_o(s1_layer_idx),
      .layer_rst_o(s1_rst), .w_addr_o(s1_addr), .w_addr_valid_o(s1_valid),
      .act_start_o(s1_act_start), .act_sel_o(s1_act_sel), .smax_en_o(s1_smax_en)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int base = 0;
   int n_total = 0;
   int n_pass = 0;
   logic prev_smax = 1'b0;
   logic prev_err = 1'b0;
   logic [63:0] q_addr[$], q_act[$], q_smax[$], q_err[$], q_done[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
      return {a[15:0], b[15:0], c[15:0], d[15:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: compares every output event against the next expected entry
   always @(negedge clk) begin : mon
      int r;
      r = cyc - base + 1;
      if (w_addr_valid_o) begin
         if (q_addr.size() == 0) chk("w_addr_unexpected", 64'(w_addr_valid_o), 64'd0);
         else chk("w_addr", pack(r, 32'(layer_idx_o), 32'(w_addr_o), 32'(layer_rst_o)),
                  q_addr.pop_front());
      end
      if (act_start_o) begin
         if (q_act.size() == 0) chk("act_start_unexpected", 64'(act_start_o), 64'd0);
         else chk("act_start", pack(r, 32'(act_sel_o), 0, 0), q_act.pop_front());
      end
      if (smax_en_o && !prev_smax) begin
         if (q_smax.size() == 0) chk("smax_en_unexpected", 64'(smax_en_o), 64'd0);
         else chk("smax_rise", pack(r, 32'(busy_o), 0, 0), q_smax.pop_front());
      end
      if (error_o && !prev_err) begin
         if (q_err.size() == 0) chk("error_unexpected", 64'(error_o), 64'd0);
         else chk("error_rise", pack(r, 32'(busy_o), 32'(layer_rst_o), 32'(smax_en_o)),
                  q_err.pop_front());
      end
      if (done_o) begin
         if (q_done.size() == 0) chk("done_unexpected", 64'(done_o), 64'd0);
         else chk("done", pack(r, 32'(busy_o), 32'(smax_en_o), 0), q_done.pop_front());
      end
      prev_smax = smax_en_o;
      prev_err  = error_o;
   end

   // One run: aw0 = act_done delay after act_start (-1 never), sw = smax_done
   // delay after smax_en rises (-1 never); abort_ofs into layer-1 LOAD and
   // rst_ofs into SMAX (-1 = not used).
   task automatic run_case(input int aw0, input int sw, input bit noise,
                           input int abort_ofs, input int rst_ofs);
      int ld[NL], ac[NL], aw[NL];
      int t, sm, err_c, done_c, lim, endc, kind;
      for (int i = 0; i < NL; i++) begin ld[i] = BIG; ac[i] = BIG; aw[i] = 0; end
      aw[0] = aw0;
      sm = BIG; err_c = -1; done_c = BIG; t = 2;
      for (int i = 0; i < NL; i++) begin
         ld[i] = t;
         t += NODES[i] + DR;
         if (i < NL - 1) begin
            ac[i] = t;
            if (aw[i] < 0) begin err_c = t + TMO; break; end
            t += aw[i] + 1;
         end else begin
            sm = t;
            if (sw < 0) err_c = t + TMO;
            else done_c = t + sw + 1;
         end
      end
      if (abort_ofs >= 0)    begin kind = 2; lim = ld[1] + abort_ofs; endc = lim + 1; end
      else if (rst_ofs >= 0) begin kind = 3; lim = sm + rst_ofs; endc = lim; end
      else if (err_c >= 0)   begin kind = 1; lim = err_c; endc = err_c; end
      else                   begin kind = 0; lim = done_c; endc = done_c; end

      for (int i = 0; i < NL; i++) begin
         for (int a = 0; a < NODES[i]; a++)
            if (ld[i] + a <= lim)
               q_addr.push_back(pack(ld[i] + a, i, a, ((1 << NL) - 1) & ~((1 << (i + 1)) - 1)));
         if (i < NL - 1 && ac[i] <= lim) q_act.push_back(pack(ac[i], i, 0, 0));
      end
      if (sm <= lim) q_smax.push_back(pack(sm, 1, 0, 0));
      if (err_c >= 0 && err_c <= lim) q_err.push_back(pack(err_c, 0, (1 << NL) - 1, 0));
      if (done_c <= lim) q_done.push_back(pack(done_c, 0, 0, 0));

      @(negedge clk);
      base = cyc + 1;
      start_i = 1'b1;
      for (int r = 1; r <= endc; r++) begin
         @(negedge clk);
         start_i = (r < endc) ? 1'($urandom_range(0, 1)) : 1'b0;
         act_done_i = 1'b0;
         for (int i = 0; i < NL - 1; i++)
            if ((aw[i] >= 0 && r == ac[i] + aw[i]) || (noise && r == ac[i])) act_done_i = 1'b1;
         smax_done_i = (sw >= 0 && r == sm + sw);
         abort_i = (kind == 2 && r == lim) || ((kind == 0 || kind == 1) && r == endc);
         if (r == 1)
            chk("clear_state", pack(32'(busy_o), 32'(error_o), 32'(layer_rst_o), 32'(w_addr_valid_o)),
                pack(1, 0, 3, 0));
         if (kind == 2 && r == endc)
            chk("abort_idle", pack(32'(busy_o), 32'(layer_rst_o), 32'(w_addr_valid_o), 32'(done_o)),
                pack(0, 3, 0, 0));
         if (kind == 3 && r == endc) begin
            #2 reset = 1'b1;
            #1;
            chk("async_reset_a", pack(32'(busy_o), 32'(done_o), 32'(error_o), 32'(smax_en_o)), 64'd0);
            chk("async_reset_b", pack(32'(layer_idx_o), 32'(w_addr_o),
                32'({w_addr_valid_o, act_start_o}), 32'(layer_rst_o)), pack(0, 0, 0, 3));
         end
      end
      @(negedge clk);
      {start_i, abort_i, act_done_i, smax_done_i} = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("pending_events", 64'(q_addr.size() + q_act.size() + q_smax.size() + q_err.size()
          + q_done.size()), 64'd0);
      q_addr.delete(); q_act.delete(); q_smax.delete(); q_err.delete(); q_done.delete();
   endtask

   initial begin
      int e;
      reset = 1'b1;
      {start_i, abort_i, act_done_i, smax_done_i} = '0;
      {s1_start, s1_abort, s1_act_done, s1_smax_done} = '0;
      repeat (3) @(negedge clk);
      chk("reset_a", pack(32'(busy_o), 32'(done_o), 32'(error_o), 32'(layer_rst_o)), pack(0, 0, 0, 3));
      chk("reset_b", pack(32'(layer_idx_o), 32'(w_addr_o),
          32'({w_addr_valid_o, act_start_o, smax_en_o}), 32'(act_sel_o)), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_case(10, 5, 1'b0, -1, -1);
      run_case(int'($urandom_range(1, 20)), int'($urandom_range(0, 15)), 1'b1, -1, -1);
      run_case(-1, 0, 1'b0, -1, -1);
      run_case(int'($urandom_range(1, 20)), int'($urandom_range(0, 15)), 1'b1, -1, -1);
      run_case(int'($urandom_range(1, 20)), 3, 1'b0, int'($urandom_range(0, 83)), -1);
      run_case(int'($urandom_range(1, 20)), 12, 1'b0, -1, int'($urandom_range(0, 11)));
      for (int k = 0; k < 3; k++)
         run_case(int'($urandom_range(1, 20)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), -1, -1);

      // Single layer, no drain: LOAD 2..5, SMAX 6, DONE 7, IDLE 8
      @(negedge clk);
      s1_start = 1'b1;
      for (int r = 1; r <= 8; r++) begin
         @(negedge clk);
         s1_start = 1'b0;
         s1_smax_done = (r == 6);
         e = ((r >= 2 && r <= 5) ? 16 : 0) | ((r == 6) ? 8 : 0) | ((r == 7) ? 4 : 0) | ((r <= 6) ? 1 : 0);
         chk("one_layer", pack(r, 32'({s1_valid, s1_smax_en, s1_done, s1_act_start, s1_busy}),
             32'(s1_addr), 32'(s1_rst)),
             pack(r, e, (r < 2) ? 0 : ((r <= 5) ? r - 2 : 3), (r >= 2) ? 0 : 1));
      end
      s1_smax_done = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
